// File: rtl/label_vote_smoother_pkg.sv
// Shared constants and FSM encoding for the A/V label vote smoother.
// Default widths match the associative-memory output format.
package label_vote_smoother_pkg;

  localparam int unsigned DEF_LABEL_WIDTH    = 2;
  localparam int unsigned DEF_DISTANCE_WIDTH = 8;
  localparam int unsigned DEF_VOTE_WINDOW    = 8;

  localparam logic [DEF_DISTANCE_WIDTH-1:0] DEF_DIST_THRESH =
    {DEF_DISTANCE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/label_vote_smoother_vote_histogram.sv
// Sliding-window label histogram for one dimension, with a
// one-class-per-cycle argmax (ties resolve to the lowest label).
module vote_histogram
  import label_vote_smoother_pkg::*;
#(
  parameter int unsigned WINDOW      = DEF_VOTE_WINDOW,
  parameter int unsigned LABEL_WIDTH = DEF_LABEL_WIDTH,
  localparam int unsigned NC = 2**LABEL_WIDTH,
  localparam int unsigned CW = $clog2(WINDOW+1),
  localparam int unsigned PW = $clog2(WINDOW)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   upd_i,
  input  logic                   admit_i,
  input  logic [LABEL_WIDTH-1:0] label_i,
  input  logic                   scan_i,
  input  logic [LABEL_WIDTH-1:0] idx_i,
  output logic [CW-1:0]          fill_o,
  output logic [LABEL_WIDTH-1:0] best_lbl_o,
  output logic [CW-1:0]          best_cnt_o
);

  logic [LABEL_WIDTH-1:0] hist_q [WINDOW];
  logic [PW-1:0]          wptr_q;
  logic [CW-1:0]          fill_q;
  logic [CW-1:0]          cnt_q [NC];
  logic [CW-1:0]          cnt_d [NC];
  logic [LABEL_WIDTH-1:0] best_lbl_q, best_lbl_d;
  logic [CW-1:0]          best_cnt_q, best_cnt_d;

  logic                   push, full;
  logic [LABEL_WIDTH-1:0] oldest;

  assign push   = upd_i & admit_i;
  assign full   = (fill_q == CW'(WINDOW));
  // Once full, the write pointer sits on the oldest entry.
  assign oldest = hist_q[wptr_q];

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      cnt_d[c] = cnt_q[c];
      if (push && label_i == LABEL_WIDTH'(c))
        cnt_d[c] = cnt_d[c] + CW'(1);
      if (push && full && oldest == LABEL_WIDTH'(c))
        cnt_d[c] = cnt_d[c] - CW'(1);
    end
  end

  always_comb begin
    best_lbl_d = best_lbl_q;
    best_cnt_d = best_cnt_q;
    if (cnt_q[idx_i] > best_cnt_q) begin
      best_lbl_d = idx_i;
      best_cnt_d = cnt_q[idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      best_lbl_q <= '0;
      best_cnt_q <= '0;
      for (int c = 0; c < NC; c++) cnt_q[c] <= '0;
      for (int i = 0; i < WINDOW; i++) hist_q[i] <= '0;
    end else if (clr_i) begin
      wptr_q     <= '0;
      fill_q     <= '0;
      best_lbl_q <= '0;
      best_cnt_q <= '0;
      for (int c = 0; c < NC; c++) cnt_q[c] <= '0;
    end else begin
      if (push) begin
        hist_q[wptr_q] <= label_i;
        wptr_q <= (wptr_q == PW'(WINDOW-1)) ? '0 : wptr_q + PW'(1);
        if (!full) fill_q <= fill_q + CW'(1);
      end
      for (int c = 0; c < NC; c++) cnt_q[c] <= cnt_d[c];
      if (upd_i) begin
        best_lbl_q <= '0;
        best_cnt_q <= '0;
      end else if (scan_i) begin
        best_lbl_q <= best_lbl_d;
        best_cnt_q <= best_cnt_d;
      end
    end
  end

  assign fill_o     = fill_q;
  assign best_lbl_o = best_lbl_d;
  assign best_cnt_o = best_cnt_d;

endmodule

// File: rtl/label_vote_smoother.sv
// Majority-vote temporal smoother for arousal/valence AM labels,
// with distance gating and a valid/ready output handshake.
module label_vote_smoother
  import label_vote_smoother_pkg::*;
#(
  parameter int unsigned WINDOW         = DEF_VOTE_WINDOW,
  parameter int unsigned LABEL_WIDTH    = DEF_LABEL_WIDTH,
  parameter int unsigned DISTANCE_WIDTH = DEF_DISTANCE_WIDTH,
  parameter logic [DISTANCE_WIDTH-1:0] DIST_THRESH =
    {DISTANCE_WIDTH{1'b1}},
  localparam int unsigned NUM_CLASSES = 2**LABEL_WIDTH,
  localparam int unsigned VW = $clog2(WINDOW+1)
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  input  logic                      Clear_SI,
  input  logic                      ValidIn_SI,
  output logic                      ReadyOut_SO,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_A_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_A_DI,
  input  logic [LABEL_WIDTH-1:0]    LabelIn_V_DI,
  input  logic [DISTANCE_WIDTH-1:0] DistanceIn_V_DI,
  output logic                      ValidOut_SO,
  input  logic                      ReadyIn_SI,
  output logic [LABEL_WIDTH-1:0]    LabelOut_A_DO,
  output logic [LABEL_WIDTH-1:0]    LabelOut_V_DO,
  output logic [VW-1:0]             VotesOut_A_DO,
  output logic [VW-1:0]             VotesOut_V_DO,
  output logic                      Reject_A_SO,
  output logic                      Reject_V_SO,
  output logic                      Full_SO
);

  state_e                    state_q, state_d;
  logic                      started_q;
  logic [LABEL_WIDTH-1:0]    idx_q, idx_d;
  logic [LABEL_WIDTH-1:0]    lbl_a_q, lbl_v_q;
  logic [DISTANCE_WIDTH-1:0] dist_a_q, dist_v_q;
  logic [LABEL_WIDTH-1:0]    out_la_q, out_lv_q;
  logic [VW-1:0]             out_va_q, out_vv_q;
  logic                      rej_a_q, rej_v_q;

  logic                      accept, upd, scan, scan_last;
  logic                      admit_a, admit_v;
  logic [VW-1:0]             fill_a, fill_v, cnt_a, cnt_v;
  logic [LABEL_WIDTH-1:0]    best_a, best_v;

  // Ready stays low until the first edge after reset release.
  assign ReadyOut_SO = started_q & (state_q == ST_IDLE) & ~Clear_SI;
  assign accept      = ValidIn_SI & ReadyOut_SO;
  assign upd         = (state_q == ST_UPDATE);
  assign scan        = (state_q == ST_SCAN);
  assign scan_last   = scan & (idx_q == LABEL_WIDTH'(NUM_CLASSES-1));
  assign admit_a     = (dist_a_q <= DIST_THRESH);
  assign admit_v     = (dist_v_q <= DIST_THRESH);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_UPDATE;
      ST_UPDATE: begin
        state_d = ST_SCAN;
        idx_d   = '0;
      end
      ST_SCAN: begin
        idx_d = idx_q + LABEL_WIDTH'(1);
        if (scan_last) state_d = ST_OUT;
      end
      ST_OUT:    if (ReadyIn_SI) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (Clear_SI) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q   <= ST_IDLE;
      started_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      idx_q     <= idx_d;
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      lbl_a_q  <= '0;
      lbl_v_q  <= '0;
      dist_a_q <= '0;
      dist_v_q <= '0;
    end else if (accept) begin
      lbl_a_q  <= LabelIn_A_DI;
      lbl_v_q  <= LabelIn_V_DI;
      dist_a_q <= DistanceIn_A_DI;
      dist_v_q <= DistanceIn_V_DI;
    end
  end

  // An empty history keeps the previously published label.
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      out_la_q <= '0;
      out_lv_q <= '0;
      out_va_q <= '0;
      out_vv_q <= '0;
      rej_a_q  <= 1'b0;
      rej_v_q  <= 1'b0;
    end else if (Clear_SI) begin
      out_la_q <= '0;
      out_lv_q <= '0;
      out_va_q <= '0;
      out_vv_q <= '0;
      rej_a_q  <= 1'b0;
      rej_v_q  <= 1'b0;
    end else if (scan_last) begin
      if (fill_a != '0) out_la_q <= best_a;
      if (fill_v != '0) out_lv_q <= best_v;
      out_va_q <= cnt_a;
      out_vv_q <= cnt_v;
      rej_a_q  <= ~admit_a;
      rej_v_q  <= ~admit_v;
    end
  end

  vote_histogram #(
    .WINDOW      (WINDOW),
    .LABEL_WIDTH (LABEL_WIDTH)
  ) u_hist_a (
    .clk_i      (Clk_CI),
    .rst_ni     (Reset_RI),
    .clr_i      (Clear_SI),
    .upd_i      (upd),
    .admit_i    (admit_a),
    .label_i    (lbl_a_q),
    .scan_i     (scan),
    .idx_i      (idx_q),
    .fill_o     (fill_a),
    .best_lbl_o (best_a),
    .best_cnt_o (cnt_a)
  );

  vote_histogram #(
    .WINDOW      (WINDOW),
    .LABEL_WIDTH (LABEL_WIDTH)
  ) u_hist_v (
    .clk_i      (Clk_CI),
    .rst_ni     (Reset_RI),
    .clr_i      (Clear_SI),
    .upd_i      (upd),
    .admit_i    (admit_v),
    .label_i    (lbl_v_q),
    .scan_i     (scan),
    .idx_i      (idx_q),
    .fill_o     (fill_v),
    .best_lbl_o (best_v),
    .best_cnt_o (cnt_v)
  );

  assign ValidOut_SO   = (state_q == ST_OUT);
  assign LabelOut_A_DO = out_la_q;
  assign LabelOut_V_DO = out_lv_q;
  assign VotesOut_A_DO = out_va_q;
  assign VotesOut_V_DO = out_vv_q;
  assign Reject_A_SO   = rej_a_q;
  assign Reject_V_SO   = rej_v_q;
  assign Full_SO       = (fill_a == VW'(WINDOW)) & (fill_v == VW'(WINDOW));

endmodule

// File: tb/tb_label_vote_smoother.sv
// Randomized self-checking bench for label_vote_smoother against a
// queue-based majority-vote reference model (WINDOW=4, 2-bit labels).
module tb_label_vote_smoother;

  localparam int WIN = 4;
  localparam int NC  = 4;
  localparam logic [7:0] TH = 8'd100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       vin = 1'b0;
  logic       rin = 1'b1;
  logic [1:0] la = '0, lv = '0;
  logic [7:0] da = '0, dv = '0;

  logic       ReadyOut, ValidOut, RejA, RejV, Full;
  logic [1:0] LabA, LabV;
  logic [2:0] VotA, VotV;

  always #5 clk = ~clk;

  label_vote_smoother #(
    .WINDOW         (WIN),
    .LABEL_WIDTH    (2),
    .DISTANCE_WIDTH (8),
    .DIST_THRESH    (TH)
  ) dut (
    .Clk_CI          (clk),
    .Reset_RI        (rst_n),
    .Clear_SI        (clr),
    .ValidIn_SI      (vin),
    .ReadyOut_SO     (ReadyOut),
    .LabelIn_A_DI    (la),
    .DistanceIn_A_DI (da),
    .LabelIn_V_DI    (lv),
    .DistanceIn_V_DI (dv),
    .ValidOut_SO     (ValidOut),
    .ReadyIn_SI      (rin),
    .LabelOut_A_DO   (LabA),
    .LabelOut_V_DO   (LabV),
    .VotesOut_A_DO   (VotA),
    .VotesOut_V_DO   (VotV),
    .Reject_A_SO     (RejA),
    .Reject_V_SO     (RejV),
    .Full_SO         (Full)
  );

  typedef struct packed {
    logic [1:0] la;
    logic [2:0] va;
    logic [1:0] lv;
    logic [2:0] vv;
    logic       ra;
    logic       rv;
    logic       full;
  } res_t;

  int checks = 0;
  int failures = 0;
  int qa[$];
  int qv[$];
  logic [1:0] pa = '0, pv = '0;

  function automatic res_t sample();
    res_t r;
    r.la = LabA; r.va = VotA; r.lv = LabV; r.vv = VotV;
    r.ra = RejA; r.rv = RejV; r.full = Full;
    return r;
  endfunction

  // Plain occurrence count over the window; first maximum wins.
  function automatic logic [4:0] vote(input int q[$], input logic [1:0] prev);
    int cnt[4];
    int best;
    int bl;
    best = 0;
    bl = 0;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (q[i]) cnt[q[i]]++;
    for (int c = 0; c < 4; c++)
      if (cnt[c] > best) begin
        best = cnt[c];
        bl = c;
      end
    if (q.size() == 0) return {prev, 3'd0};
    return {2'(bl), 3'(best)};
  endfunction

  task automatic model_step(input logic [1:0] a, input logic [7:0] ad,
                            input logic [1:0] v, input logic [7:0] vd,
                            output res_t e);
    logic [4:0] ra, rv;
    if (ad <= TH) begin
      qa.push_back(int'(a));
      if (qa.size() > WIN) void'(qa.pop_front());
    end
    if (vd <= TH) begin
      qv.push_back(int'(v));
      if (qv.size() > WIN) void'(qv.pop_front());
    end
    ra = vote(qa, pa);
    rv = vote(qv, pv);
    pa = ra[4:3];
    pv = rv[4:3];
    e.la = ra[4:3]; e.va = ra[2:0];
    e.lv = rv[4:3]; e.vv = rv[2:0];
    e.ra = (ad > TH); e.rv = (vd > TH);
    e.full = (qa.size() == WIN) && (qv.size() == WIN);
  endtask

  task automatic model_clear();
    qa.delete();
    qv.delete();
    pa = '0;
    pv = '0;
  endtask

  // Runs one transaction; entered and left 1ns after a rising edge.
  task automatic do_txn(input logic [1:0] a, input logic [7:0] ad,
                        input logic [1:0] v, input logic [7:0] vd,
                        input int hold, output res_t obs,
                        output int lat, output bit hold_ok);
    int n;
    n = 0;
    hold_ok = 1'b1;
    while (!ReadyOut && n < 50) begin
      @(posedge clk); #1; n++;
    end
    la = a; da = ad; lv = v; dv = vd;
    vin = 1'b1;
    rin = (hold == 0);
    @(posedge clk); #1;
    vin = 1'b0;
    lat = 0;
    while (!ValidOut && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    obs = sample();
    for (int i = 0; i < hold; i++) begin
      if (i == hold / 2) begin
        vin = 1'b1; la = ~a; da = '0; lv = ~v; dv = '0;
      end
      @(posedge clk); #1;
      vin = 1'b0;
      if (!ValidOut || ReadyOut || sample() !== obs) hold_ok = 1'b0;
    end
    rin = 1'b1;
    @(posedge clk); #1;
    if (ValidOut) hold_ok = 1'b0;
  endtask

  task automatic test_reset();
    #22;
    checks++;
    if ({ValidOut, ReadyOut, sample()} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {ValidOut, ReadyOut, sample()});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ReadyOut !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early got=%b exp=0", ReadyOut);
    end
    @(posedge clk); #1;
    checks++;
    if (ReadyOut !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge got=%b exp=1", ReadyOut);
    end
  endtask

  task automatic test_window();
    logic [1:0] seq_a[6] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    res_t obs, e;
    int lat;
    bit ok;
    logic [1:0] v;
    logic [7:0] vd;
    for (int i = 0; i < 6; i++) begin
      v = 2'($urandom_range(0, 3));
      vd = (i == 0) ? 8'd200 : 8'd20;
      do_txn(seq_a[i], 8'd10, v, vd, 0, obs, lat, ok);
      model_step(seq_a[i], 8'd10, v, vd, e);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL window_s%0d got=%h exp=%h", i, obs, e);
      end
      checks++;
      if (lat !== NC + 1 || !ok) begin
        failures++;
        $display("FAIL window_lat_s%0d got=%0d/%0b exp=%0d/1", i, lat, ok, NC + 1);
      end
      if (i == 3) begin
        checks++;
        if (obs.la !== 2'd1 || obs.va !== 3'd2 || obs.full !== 1'b0) begin
          failures++;
          $display("FAIL window_fourth got=%0d/%0d/%0b exp=1/2/0", obs.la, obs.va, obs.full);
        end
      end
      if (i == 5) begin
        checks++;
        if (obs.la !== 2'd2 || obs.va !== 3'd3 || obs.full !== 1'b1) begin
          failures++;
          $display("FAIL window_evict got=%0d/%0d/%0b exp=2/3/1", obs.la, obs.va, obs.full);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [1:0] seq_a[4] = '{2'd3, 2'd0, 2'd3, 2'd0};
    res_t obs, e;
    int lat;
    bit ok;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 2'($urandom_range(0, 3));
      do_txn(seq_a[i], 8'd5, v, 8'd5, 0, obs, lat, ok);
      model_step(seq_a[i], 8'd5, v, 8'd5, e);
      checks++;
      if (obs !== e || lat !== NC + 1 || !ok) begin
        failures++;
        $display("FAIL tie_s%0d got=%h exp=%h lat=%0d", i, obs, e, lat);
      end
    end
    checks++;
    if (obs.la !== 2'd0 || obs.va !== 3'd2) begin
      failures++;
      $display("FAIL tie_lowest got=%0d/%0d exp=0/2", obs.la, obs.va);
    end
  endtask

  task automatic test_reject();
    logic [1:0] al[3] = '{2'd3, 2'd1, 2'd2};
    logic [7:0] ad[3] = '{8'd150, 8'd100, 8'd101};
    logic [1:0] v;
    res_t obs, e, prev;
    int lat;
    bit ok;
    prev = sample();
    for (int i = 0; i < 3; i++) begin
      v = 2'($urandom_range(0, 3));
      do_txn(al[i], ad[i], v, 8'd0, 0, obs, lat, ok);
      model_step(al[i], ad[i], v, 8'd0, e);
      checks++;
      if (obs !== e || lat !== NC + 1 || !ok) begin
        failures++;
        $display("FAIL reject_s%0d got=%h exp=%h lat=%0d", i, obs, e, lat);
      end
      if (i == 0) begin
        checks++;
        if (obs.ra !== 1'b1 || obs.rv !== 1'b0 ||
            obs.la !== prev.la || obs.va !== prev.va) begin
          failures++;
          $display("FAIL reject_gate got=%h prev=%h", obs, prev);
        end
      end
      if (i == 1) begin
        checks++;
        if (obs.ra !== 1'b0) begin
          failures++;
          $display("FAIL reject_thresh_equal got=%b exp=0", obs.ra);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t obs, e;
    int lat;
    bit ok;
    do_txn(2'd1, 8'd3, 2'd2, 8'd3, 10, obs, lat, ok);
    model_step(2'd1, 8'd3, 2'd2, 8'd3, e);
    checks++;
    if (obs !== e || lat !== NC + 1) begin
      failures++;
      $display("FAIL backpressure_result got=%h exp=%h lat=%0d", obs, e, lat);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL backpressure_hold got=0 exp=1");
    end
    do_txn(2'd3, 8'd3, 2'd0, 8'd3, 0, obs, lat, ok);
    model_step(2'd3, 8'd3, 2'd0, 8'd3, e);
    checks++;
    if (obs !== e || !ok) begin
      failures++;
      $display("FAIL backpressure_next got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_clear();
    res_t obs, e;
    int lat;
    bit ok;
    bit seen;
    la = 2'd2; da = 8'd1; lv = 2'd1; dv = 8'd1;
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < NC + 4; i++) begin
      if (ValidOut) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || sample() !== '0) begin
      failures++;
      $display("FAIL clear_scan got=%0b/%h exp=0/0", seen, sample());
    end
    vin = 1'b1;
    clr = 1'b1;
    #1;
    checks++;
    if (ReadyOut !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready got=%b exp=0", ReadyOut);
    end
    @(posedge clk); #1;
    vin = 1'b0;
    clr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NC + 4; i++) begin
      if (ValidOut) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL clear_priority got=1 exp=0");
    end
    do_txn(2'd3, 8'd9, 2'd2, 8'd9, 0, obs, lat, ok);
    model_step(2'd3, 8'd9, 2'd2, 8'd9, e);
    checks++;
    if (obs !== e || obs.va !== 3'd1 || obs.vv !== 3'd1 || obs.full !== 1'b0) begin
      failures++;
      $display("FAIL clear_restart got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_random();
    res_t obs, e;
    int lat;
    bit ok;
    logic [1:0] a, v;
    logic [7:0] ad, vd;
    int hold;
    for (int i = 0; i < 40; i++) begin
      a = 2'($urandom_range(0, 3));
      v = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 7) == 0) ? 8'(100 + $urandom_range(0, 1))
                                       : 8'($urandom_range(0, 130));
      vd = 8'($urandom_range(0, 130));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_txn(a, ad, v, vd, hold, obs, lat, ok);
      model_step(a, ad, v, vd, e);
      checks++;
      if (obs !== e || lat !== NC + 1 || !ok) begin
        failures++;
        $display("FAIL random_%0d got=%h exp=%h lat=%0d ok=%0b", i, obs, e, lat, ok);
      end
    end
  endtask

  task automatic test_async_reset();
    res_t obs, e;
    int lat;
    bit ok;
    la = 2'd1; da = 8'd0; lv = 2'd3; dv = 8'd0;
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ValidOut, ReadyOut, sample()} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {ValidOut, ReadyOut, sample()});
    end
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    do_txn(2'd2, 8'd4, 2'd1, 8'd4, 0, obs, lat, ok);
    model_step(2'd2, 8'd4, 2'd1, 8'd4, e);
    checks++;
    if (obs !== e || lat !== NC + 1 || !ok) begin
      failures++;
      $display("FAIL async_restart got=%h exp=%h lat=%0d", obs, e, lat);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_tie();
    test_reject();
    test_backpressure();
    test_clear();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
